bcd_score_counter: RTL and testbench
====================================

// Module: bcd_score_counter
// PURPOSE
//  Two-digit BCD up/down counter holding the game score/level. Produces ones/tens
//  nibbles that feed two segment_display decoder instances directly.
//  Nibble 4'hF is the "blank" code; the decoder turns any non-0..9 code into all
//  segments off. Sits between game-event logic (score pulses) and the 7-seg drivers.
// PARAMETERS
//  MAX_VALUE     99        highest count, decimal 1..99
//  WRAP          1         1: inc past MAX_VALUE -> 0, dec below 0 -> MAX_VALUE; 0: saturate
//  LZ_BLANK      1         1: tens nibble reads 4'hF while tens digit is 0
//  FLASH_CYCLES  25000000  clocks per flash half-period (used only with SCORE_FLASH_EN)
//  FLASH_COUNT   3         number of blank/show flash pairs (used only with SCORE_FLASH_EN)
// PORTS
//  i_Clk        in   1  system clock; all logic on rising edge
//  i_Rst_n      in   1  asynchronous active-low reset
//  i_Clear      in   1  synchronous clear to 00; highest priority after reset
//  i_Inc        in   1  one-cycle pulse: count +1
//  i_Dec        in   1  one-cycle pulse: count -1
//  o_Ones       out  4  ones BCD digit 0..9, or 4'hF when blanked
//  o_Tens       out  4  tens BCD digit 0..9, or 4'hF when blanked
//  o_Zero       out  1  high while internal count == 0
//  o_Wrap       out  1  one-cycle pulse on wrap, or on a saturated inc/dec attempt
// BEHAVIOUR
//  - Internal state: ones_q[3:0] and tens_q[3:0], BCD only (never 4'hA..4'hF).
//  - All outputs are registered. Reset values: count 00, o_Ones=0, o_Tens=4'hF if
//    LZ_BLANK else 0, o_Zero=1, o_Wrap=0, FSM=S_RUN.
//  - Latency: an event sampled at edge N is visible on the outputs after edge N.
//  - Priority per cycle: i_Clear > (i_Inc XOR i_Dec). i_Inc and i_Dec together is a
//    no-op. i_Clear also drops any flash and forces o_Wrap=0.
//  - Inc: ones 9 -> 0 with tens+1. Inc at MAX_VALUE:
//      WRAP=1 -> count 00, o_Wrap=1.
//      WRAP=0 -> count unchanged, o_Wrap=1.
//  - Dec: ones 0 -> 9 with tens-1. Dec at 00:
//      WRAP=1 -> count MAX_VALUE, o_Wrap=1.
//      WRAP=0 -> count stays 00, o_Wrap=1.
//  - Compare against MAX_VALUE in BCD: tens==MAX_VALUE/10 && ones==MAX_VALUE%10.
//  - Level-held i_Inc counts once per cycle. Upstream must supply pulses.
//  - o_Tens = 4'hF when LZ_BLANK=1 and tens_q==0. Ones digit is never LZ-blanked.
//  - FSM: S_RUN, S_FLASH_OFF, S_FLASH_ON. Flash states exist only with the macro.
//    Without the macro the FSM is fixed at S_RUN.
// CONFIGURATION
//  SCORE_FLASH_EN defined:
//  - Any o_Wrap pulse moves S_RUN -> S_FLASH_OFF, with timer=0 and pair counter=0.
//  - S_FLASH_OFF: o_Ones=o_Tens=4'hF for FLASH_CYCLES clocks, then -> S_FLASH_ON.
//  - S_FLASH_ON: normal digits for FLASH_CYCLES clocks, then pair counter +1.
//    Exit to S_RUN after FLASH_COUNT pairs; otherwise -> S_FLASH_OFF.
//  - Counting continues during flash; shown digits always reflect the live count.
//  - A new o_Wrap during flash restarts the flash from S_FLASH_OFF with counters 0.
//  - Reset or i_Clear mid-flash -> S_RUN immediately.
//  SCORE_FLASH_EN undefined:
//  - No timer or FSM registers are synthesised. Outputs are never flash-blanked.
//  - FLASH_* parameters are ignored.
// TESTING
//  Benches use MAX_VALUE=12, FLASH_CYCLES=4, FLASH_COUNT=2.
//  1. Reset, then 11 single-cycle i_Inc pulses
//     -> o_Tens/o_Ones = F/1,...,F/9, then 1/0, 1/1; o_Zero=0 after the first pulse.
//  2. WRAP=1, count 12, i_Inc -> 00, o_Wrap=1 for exactly 1 cycle, o_Tens=F.
//     Then i_Dec -> 1/2 with o_Wrap=1.
//  3. WRAP=0, count 12, i_Inc -> stays 1/2, o_Wrap=1.
//     Count 00, i_Dec -> stays F/0, o_Zero=1.
//  4. Count 1/0: i_Inc+i_Dec together -> unchanged.
//     i_Clear+i_Inc together -> F/0.
//     i_Rst_n low mid-cycle -> outputs reset asynchronously, before the next edge.
//  5. SCORE_FLASH_EN, WRAP=1, wrap event
//     -> 4 clocks F/F, 4 clocks live digits, repeated twice, then steady live digits.
//     An i_Inc during the flash is reflected in the next on-phase.
//  6. SCORE_FLASH_EN, second wrap at clock 6 of the flash -> sequence restarts with F/F.
//     i_Clear in S_FLASH_OFF -> F/0 on the next cycle, no further blanking.

Source files
------------

// File: rtl/bcd_score_counter.sv
// Two-digit BCD up/down score counter with registered outputs for 7-seg decoders.
// Optional wrap flash (blank/show pairs after every o_Wrap) enabled by `define SCORE_FLASH_EN.
module bcd_score_counter #(
  parameter int unsigned MAX_VALUE    = 99,
  parameter int unsigned WRAP         = 1,
  parameter int unsigned LZ_BLANK     = 1,
  parameter int unsigned FLASH_CYCLES = 25000000,
  parameter int unsigned FLASH_COUNT  = 3
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic       i_Clear,
  input  logic       i_Inc,
  input  logic       i_Dec,
  output logic [3:0] o_Ones,
  output logic [3:0] o_Tens,
  output logic       o_Zero,
  output logic       o_Wrap
);

  localparam logic [3:0] MAX_T = 4'(MAX_VALUE / 10);
  localparam logic [3:0] MAX_O = 4'(MAX_VALUE % 10);
  localparam logic [3:0] BLANK = 4'hF;

  logic [3:0] r_ones, r_tens;
  logic [3:0] w_ones_nx, w_tens_nx;
  logic       w_wrap_nx, w_at_max, w_at_zero, w_blank_nx;

  assign w_at_max  = (r_tens == MAX_T) && (r_ones == MAX_O);
  assign w_at_zero = (r_tens == 4'd0) && (r_ones == 4'd0);

  always_comb begin
    w_ones_nx = r_ones;
    w_tens_nx = r_tens;
    w_wrap_nx = 1'b0;
    if (i_Clear) begin
      w_ones_nx = '0;
      w_tens_nx = '0;
    end else if (i_Inc && !i_Dec) begin
      if (w_at_max) begin
        w_wrap_nx = 1'b1;
        if (WRAP != 0) begin
          w_ones_nx = '0;
          w_tens_nx = '0;
        end
      end else if (r_ones == 4'd9) begin
        w_ones_nx = '0;
        w_tens_nx = r_tens + 4'd1;
      end else begin
        w_ones_nx = r_ones + 4'd1;
      end
    end else if (i_Dec && !i_Inc) begin
      if (w_at_zero) begin
        w_wrap_nx = 1'b1;
        if (WRAP != 0) begin
          w_ones_nx = MAX_O;
          w_tens_nx = MAX_T;
        end
      end else if (r_ones == 4'd0) begin
        w_ones_nx = 4'd9;
        w_tens_nx = r_tens - 4'd1;
      end else begin
        w_ones_nx = r_ones - 4'd1;
      end
    end
  end

`ifdef SCORE_FLASH_EN
  typedef enum logic [1:0] {S_RUN, S_FLASH_OFF, S_FLASH_ON} state_t;

  localparam int unsigned TW = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
  localparam int unsigned PW = (FLASH_COUNT > 1) ? $clog2(FLASH_COUNT) : 1;

  state_t          r_state, w_state_nx;
  logic [TW-1:0]   r_timer, w_timer_nx;
  logic [PW-1:0]   r_pairs, w_pairs_nx;
  logic            w_timer_done;

  assign w_timer_done = (r_timer == TW'(FLASH_CYCLES - 1));

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_state <= S_RUN;
      r_timer <= '0;
      r_pairs <= '0;
    end else begin
      r_state <= w_state_nx;
      r_timer <= w_timer_nx;
      r_pairs <= w_pairs_nx;
    end
  end

  // Wrap restarts the flash from any state; clear aborts it.
  always_comb begin
    w_state_nx = r_state;
    w_timer_nx = r_timer;
    w_pairs_nx = r_pairs;
    if (i_Clear) begin
      w_state_nx = S_RUN;
      w_timer_nx = '0;
      w_pairs_nx = '0;
    end else if (w_wrap_nx) begin
      w_state_nx = S_FLASH_OFF;
      w_timer_nx = '0;
      w_pairs_nx = '0;
    end else begin
      case (r_state)
        S_FLASH_OFF: begin
          if (w_timer_done) begin
            w_state_nx = S_FLASH_ON;
            w_timer_nx = '0;
          end else begin
            w_timer_nx = r_timer + 1'b1;
          end
        end
        S_FLASH_ON: begin
          if (w_timer_done) begin
            w_timer_nx = '0;
            if (r_pairs == PW'(FLASH_COUNT - 1)) begin
              w_state_nx = S_RUN;
              w_pairs_nx = '0;
            end else begin
              w_state_nx = S_FLASH_OFF;
              w_pairs_nx = r_pairs + 1'b1;
            end
          end else begin
            w_timer_nx = r_timer + 1'b1;
          end
        end
        default: w_state_nx = S_RUN;
      endcase
    end
  end

  assign w_blank_nx = (w_state_nx == S_FLASH_OFF);
`else
  localparam int unsigned FLASH_CFG_UNUSED = FLASH_CYCLES + FLASH_COUNT;
  assign w_blank_nx = 1'b0;
`endif

  // Outputs are computed from next-state values so they update on the same edge.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_ones <= '0;
      r_tens <= '0;
      o_Ones <= '0;
      o_Tens <= (LZ_BLANK != 0) ? BLANK : 4'd0;
      o_Zero <= 1'b1;
      o_Wrap <= 1'b0;
    end else begin
      r_ones <= w_ones_nx;
      r_tens <= w_tens_nx;
      o_Ones <= w_blank_nx ? BLANK : w_ones_nx;
      o_Tens <= (w_blank_nx || ((LZ_BLANK != 0) && (w_tens_nx == 4'd0))) ? BLANK : w_tens_nx;
      o_Zero <= (w_ones_nx == 4'd0) && (w_tens_nx == 4'd0);
      o_Wrap <= w_wrap_nx;
    end
  end

endmodule

// File: tb/tb_bcd_score_counter.sv
// Scoreboard bench for bcd_score_counter: WRAP=1 and WRAP=0 instances share stimulus,
// a decimal-arithmetic model predicts each cycle's outputs.
module tb_bcd_score_counter;

  localparam int MAXV = 12;
  localparam int FC   = 4;
  localparam int FN   = 2;
`ifdef SCORE_FLASH_EN
  localparam bit FLASH_MODEL = 1'b1;
`else
  localparam bit FLASH_MODEL = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] ones;
    logic [3:0] tens;
    logic       zero;
    logic       wrap;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0, inc = 1'b0, dec = 1'b0;
  logic [3:0] ones1, tens1, ones0, tens0;
  logic       zero1, wrap1, zero0, wrap0;

  obs_t q1[$];
  obs_t q0[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cnt[2];
  int   age[2];

  always #5 clk = ~clk;

  bcd_score_counter #(.MAX_VALUE(MAXV), .WRAP(1), .LZ_BLANK(1),
                      .FLASH_CYCLES(FC), .FLASH_COUNT(FN)) u_dut_w1 (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Clear(clr), .i_Inc(inc), .i_Dec(dec),
    .o_Ones(ones1), .o_Tens(tens1), .o_Zero(zero1), .o_Wrap(wrap1));

  bcd_score_counter #(.MAX_VALUE(MAXV), .WRAP(0), .LZ_BLANK(1),
                      .FLASH_CYCLES(FC), .FLASH_COUNT(FN)) u_dut_w0 (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Clear(clr), .i_Inc(inc), .i_Dec(dec),
    .o_Ones(ones0), .o_Tens(tens0), .o_Zero(zero0), .o_Wrap(wrap0));

  function automatic obs_t expect_out(int c, int a, logic w);
    obs_t e;
    bit   blank;
    blank  = FLASH_MODEL && (a >= 0) && (a < 2*FC*FN) && ((a % (2*FC)) < FC);
    e.ones = blank ? 4'hF : 4'(c % 10);
    e.tens = (blank || (c / 10) == 0) ? 4'hF : 4'(c / 10);
    e.zero = (c == 0);
    e.wrap = w;
    return e;
  endfunction

  // age = clocks since the last wrap event, -1 when no flash is running
  task automatic model_step(input int k, input bit wrapmode, input bit c, input bit i,
                            input bit d, output obs_t e);
    int   n;
    logic w;
    w = 1'b0;
    if (c) begin
      cnt[k] = 0;
      age[k] = -1;
    end else begin
      if (age[k] >= 0) age[k] = (age[k] + 1 >= 2*FC*FN) ? -1 : age[k] + 1;
      if (i != d) begin
        n = cnt[k] + (i ? 1 : -1);
        if (n > MAXV || n < 0) begin
          w = 1'b1;
          if (wrapmode) cnt[k] = (n > MAXV) ? 0 : MAXV;
        end else begin
          cnt[k] = n;
        end
      end
      if (w) age[k] = 0;
    end
    e = expect_out(cnt[k], age[k], w);
  endtask

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got ones=%h tens=%h zero=%b wrap=%b, expected ones=%h tens=%h zero=%b wrap=%b",
               name, act.ones, act.tens, act.zero, act.wrap,
               exp.ones, exp.tens, exp.zero, exp.wrap);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      cnt[k] = 0;
      age[k] = -1;
    end
  endtask

  task automatic drive(input bit c, input bit i, input bit d);
    obs_t e;
    @(negedge clk);
    clr = c; inc = i; dec = d;
    model_step(1, 1'b1, c, i, d, e);
    q1.push_back(e);
    model_step(0, 1'b0, c, i, d, e);
    q0.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) drive(0, 0, 0);
  endtask

  task automatic check_reset_state(input string tag);
    obs_t r;
    r = expect_out(0, -1, 1'b0);
    check({tag, "_w1"}, {ones1, tens1, zero1, wrap1}, r);
    check({tag, "_w0"}, {ones0, tens0, zero0, wrap0}, r);
  endtask

  // Monitor: every clock the DUT presents a fresh registered result.
  initial begin
    obs_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check("cycle_w1", {ones1, tens1, zero1, wrap1}, e);
      end
      if (q0.size() > 0) begin
        e = q0.pop_front();
        check("cycle_w0", {ones0, tens0, zero0, wrap0}, e);
      end
    end
  end

  initial begin
    int r;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;

    // count up through the tens carry, to MAX, then past it
    repeat (12) drive(0, 1, 0);
    drive(0, 1, 0);
    idle(3);
    drive(0, 0, 1);
    idle(20);

    // dec at zero, simultaneous inc/dec, clear beating inc
    drive(1, 0, 0);
    drive(0, 0, 1);
    idle(18);
    drive(1, 0, 0);
    repeat (10) drive(0, 1, 0);
    drive(0, 1, 1);
    drive(1, 1, 0);
    repeat (3) drive(0, 1, 0);

    // asynchronous reset mid-cycle, checked before the next edge
    @(negedge clk);
    clr = 0; inc = 0; dec = 0;
    #1 rst_n = 1'b0;
    #1 check_reset_state("async_rst");
    #1 rst_n = 1'b1;
    model_reset();

    // flash restart by a second wrap, inc during flash, clear during off-phase
    drive(0, 0, 1);
    idle(5);
    drive(0, 0, 1);
    idle(5);
    drive(0, 1, 0);
    idle(14);
    drive(0, 1, 0);
    drive(0, 0, 0);
    drive(1, 0, 0);
    idle(18);

    for (int j = 0; j < 600; j++) begin
      r = $urandom_range(0, 99);
      if (r < 3)       drive(1, 0, 0);
      else if (r < 45) drive(0, 1, 0);
      else if (r < 80) drive(0, 0, 1);
      else if (r < 86) drive(0, 1, 1);
      else             drive(0, 0, 0);
    end

    @(negedge clk);
    clr = 0; inc = 0; dec = 0;
    for (int j = 0; j < 5 && (q1.size() > 0 || q0.size() > 0); j++) @(negedge clk);
    n_tests++;
    if (q1.size() > 0 || q0.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d/%0d entries left, expected 0", q1.size(), q0.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
